// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide unit.
//   op_e    - MIPS HI/LO operation select (MULT, MULTU, DIV, DIVU)
//   state_e - unit FSM states
//   N_ITER  - iterations of the shift-add / restoring-divide loop
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int          N_ITER    = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // op[1] selects divide, op[0] selects unsigned
    function automatic logic is_div(op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed(op_e op);
        return !op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request / HI-LO write bus of the multiply/divide unit.
//   start, op, opA, opB, cancel : execute stage -> unit
//   busy, done                  : unit -> pipeline control
//   wHiData, wLoData, whi, wlo  : unit -> HI/LO register file write port
//   modport master = execute stage side, modport slave = muldiv_unit
interface muldiv_unit_if;
    import muldiv_pkg::*;

    logic        start;
    op_e         op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] wHiData;
    logic [31:0] wLoData;
    logic        whi;
    logic        wlo;

    modport master (
        output start, op, opA, opB, cancel,
        input  busy, done, wHiData, wLoData, whi, wlo
    );

    modport slave (
        input  start, op, opA, opB, cancel,
        output busy, done, wHiData, wLoData, whi, wlo
    );

endinterface

// File: rtl/muldiv_unit_div_core.sv
// div_core: combinational divide datapath for muldiv_unit.
//   i_signed, i_a, i_b        -> o_abs_a, o_abs_b : operand magnitudes
//   i_rem, i_quot, i_dvs      -> o_rem, o_quot    : one restoring radix-2 step
//   i_neg_q, i_neg_r          -> o_lo, o_hi       : sign-fixed step result
module div_core (
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_abs_a,
    output logic [31:0] o_abs_b,
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quot,
    input  logic [31:0] i_dvs,
    output logic [31:0] o_rem,
    output logic [31:0] o_quot,
    input  logic        i_neg_q,
    input  logic        i_neg_r,
    output logic [31:0] o_lo,
    output logic [31:0] o_hi
);
    logic [32:0] w_sh;
    logic [32:0] w_diff;
    logic        w_ge;

    // -0x80000000 wraps to 0x80000000, which is the correct magnitude unsigned
    assign o_abs_a = (i_signed && i_a[31]) ? -i_a : i_a;
    assign o_abs_b = (i_signed && i_b[31]) ? -i_b : i_b;

    // rem < dvs always holds, so the shifted rem is < 2*dvs and the 33-bit
    // difference lies in (-2^32, 2^32): bit 32 is a valid sign.
    assign w_sh   = {i_rem, i_quot[31]};
    assign w_diff = w_sh - {1'b0, i_dvs};
    assign w_ge   = !w_diff[32];

    assign o_rem  = w_ge ? w_diff[31:0] : w_sh[31:0];
    assign o_quot = {i_quot[30:0], w_ge};

    assign o_lo = i_neg_q ? -o_quot : o_quot;
    assign o_hi = i_neg_r ? -o_rem  : o_rem;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit driving the HI/LO write port.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : muldiv_unit_if.slave (request, busy/done, HI/LO write port)
// Optional build macro MULDIV_FAST_MULT_EN: multiplies complete in one cycle
// through a combinational 32x32 multiplier; the iterative multiply path is
// removed. Divide is iterative in both builds.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    muldiv_unit_if.slave  bus
);
    state_e      r_state;
    logic [4:0]  r_cnt;
    op_e         r_op;
    logic [31:0] r_opnd;     // multiplicand or divisor magnitude
    logic [31:0] r_hi;       // accumulator high / partial remainder
    logic [31:0] r_lo;       // multiplier bits / quotient bits
    logic        r_neg_q;    // negate product or quotient
    logic        r_neg_r;    // negate remainder
    logic [31:0] r_out_hi;
    logic [31:0] r_out_lo;

    logic        w_sgn_in;
    logic        w_neg_in;
    logic [31:0] w_abs_a, w_abs_b;
    logic [31:0] w_d_rem, w_d_quot;
    logic [31:0] w_fix_hi, w_fix_lo;
    logic [63:0] w_next;
    logic [63:0] w_final;

    assign w_sgn_in = is_signed(bus.op);
    assign w_neg_in = w_sgn_in & (bus.opA[31] ^ bus.opB[31]);

    div_core u_div (
        .i_signed (w_sgn_in),
        .i_a      (bus.opA),
        .i_b      (bus.opB),
        .o_abs_a  (w_abs_a),
        .o_abs_b  (w_abs_b),
        .i_rem    (r_hi),
        .i_quot   (r_lo),
        .i_dvs    (r_opnd),
        .o_rem    (w_d_rem),
        .o_quot   (w_d_quot),
        .i_neg_q  (r_neg_q),
        .i_neg_r  (r_neg_r),
        .o_lo     (w_fix_lo),
        .o_hi     (w_fix_hi)
    );

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] w_fast_umul;
    logic [63:0] w_fast_prod;

    assign w_fast_umul = 64'(w_abs_a) * 64'(w_abs_b);
    assign w_fast_prod = w_neg_in ? -w_fast_umul : w_fast_umul;
    assign w_next      = {w_d_rem, w_d_quot};
    assign w_final     = {w_fix_hi, w_fix_lo};
`else
    logic [32:0] w_m_sum;
    logic [63:0] w_m_next;

    // Shift-right multiply: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift {carry, hi, lo} right.
    assign w_m_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_m_next = {w_m_sum, r_lo[31:1]};
    assign w_next   = is_div(r_op) ? {w_d_rem, w_d_quot} : w_m_next;
    assign w_final  = is_div(r_op) ? {w_fix_hi, w_fix_lo}
                                   : (r_neg_q ? -w_m_next : w_m_next);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MULT;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_out_hi <= '0;
            r_out_lo <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        r_op    <= bus.op;
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_neg_q <= w_neg_in;
                        r_neg_r <= w_sgn_in & bus.opA[31];
                        // divide: {rem, quot} = {0, |A|}; multiply: {acc, mplier} = {0, |B|}
                        r_lo    <= is_div(bus.op) ? w_abs_a : w_abs_b;
                        r_opnd  <= is_div(bus.op) ? w_abs_b : w_abs_a;
                        if (is_div(bus.op) && bus.opB == '0) begin
                            r_out_hi <= bus.opA;
                            r_out_lo <= DIV0_QUOT;
                            r_state  <= ST_DONE;
                        end
`ifdef MULDIV_FAST_MULT_EN
                        else if (!is_div(bus.op)) begin
                            {r_out_hi, r_out_lo} <= w_fast_prod;
                            r_state              <= ST_DONE;
                        end
`endif
                        else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.cancel) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt        <= r_cnt + 5'd1;
                        {r_hi, r_lo} <= w_next;
                        if (r_cnt == 5'(N_ITER - 1)) begin
                            {r_out_hi, r_out_lo} <= w_final;
                            r_state              <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // cancel in DONE must kill the HI/LO write in the same cycle
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_DONE) && !bus.cancel;
    assign bus.whi     = bus.done;
    assign bus.wlo     = bus.done;
    assign bus.wHiData = r_out_hi;
    assign bus.wLoData = r_out_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + randomized checks of muldiv_unit against an
// arithmetic reference model. Honours MULDIV_FAST_MULT_EN for multiply latency.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference: {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        logic [63:0]     res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: begin q = sa * sb; res = q; end
            2'b01: begin p = ua * ub; res = p; end
            2'b10: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin p = ua / ub; res = {32'(ua % ub), p[31:0]}; end
            end
        endcase
        return res;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        if (o[1] && b == 32'd0) return 1;
`ifdef MULDIV_FAST_MULT_EN
        if (!o[1]) return 1;
`endif
        return 33;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit poke);
        int          lat, dc;
        logic [63:0] got;
        logic [1:0]  we;
        lat = exp_lat(o, b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op_e'(o); bus.opA = a; bus.opB = b;
        @(posedge clk); #1;
        // operands must have been latched; scramble the bus
        bus.start = 1'b0; bus.opA = $urandom; bus.opB = $urandom;
        dc = 0; got = '0; we = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) chk("busy_c1", bus.busy, 1);
            if (poke && c == 5) begin bus.start = 1'b1; bus.op = op_e'($urandom_range(0, 3)); end
            if (poke && c == 6) bus.start = 1'b0;
            if (bus.done) begin
                dc  = c;
                got = {bus.wHiData, bus.wLoData};
                we  = {bus.whi, bus.wlo};
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("latency", dc, lat);
        chk("result", got, exp);
        chk("wen", we, 2'b11);
        @(posedge clk); #1;
        chk("done_pulse", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("hold", {bus.wHiData, bus.wLoData}, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        bit          saw;

        rst = 1'b1; bus.start = 1'b0; bus.cancel = 1'b0;
        bus.op = OP_MULT; bus.opA = '0; bus.opB = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_wen", {bus.whi, bus.wlo}, 0);
        chk("rst_data", {bus.wHiData, bus.wLoData}, 0);
        rst = 1'b0;

        // directed cases
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op(2'b11, 32'd100,       32'd7,        64'h0000_0002_0000_000E, 1'b1);
        run_op(2'b11, 32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0,        64'hFFFF_FFF9_FFFF_FFFF, 1'b0);
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);

        // cancel during CALC at cycle 10, then restart in the first IDLE cycle
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.opA = 32'd1000; bus.opB = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        saw = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (bus.whi || bus.wlo) saw = 1'b1;
            @(posedge clk); #1;
        end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        chk("cancel_busy", bus.busy, 0);
        chk("cancel_nowrite", {saw, bus.whi, bus.wlo}, 0);
        run_op(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);

        // cancel in DONE suppresses the write pulse in that cycle
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.opA = 32'd50; bus.opB = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (32) begin @(posedge clk); #1; end
        chk("done_pre_cancel", bus.done, 1);
        bus.cancel = 1'b1;
        #1;
        chk("done_cancel", {bus.done, bus.whi, bus.wlo}, 0);
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        chk("done_cancel_idle", bus.busy, 0);

        // reset at cycle 20 of a DIV
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.opA = 32'h1234_5678; bus.opB = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out", {bus.busy, bus.done, bus.whi, bus.wlo}, 0);
        chk("midrst_data", {bus.wHiData, bus.wLoData}, 0);
        saw = 1'b0;
        repeat (20) begin
            if (bus.done || bus.busy) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk("midrst_nowrite", saw, 0);

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'd1;
                3: b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            if (i % 9 == 0) a = 32'h8000_0000;
            run_op(o, a, b, model(o, a, b), (i % 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit for the MIPS execute stage. It computes MULT/MULTU/DIV/DIVU results and drives the HI/LO register file's write port directly (wHiData/wLoData/whi/wlo). It holds the pipeline through `busy` while iterating and supports flush via `cancel`.

## Interface
- No parameters; data width fixed at 32.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch request; sampled only in IDLE.
- `op` in 2: operation; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `opA` in 32: multiplicand / dividend.
- `opB` in 32: multiplier / divisor.
- `cancel` in 1: flush; aborts any operation without a write.
- `busy` out 1: high in CALC and DONE states.
- `done` out 1: one-cycle result-valid pulse.
- `wHiData` out 32: HI result (product[63:32] / remainder).
- `wLoData` out 32: LO result (product[31:0] / quotient).
- `whi` out 1: HI write enable; equals `done`.
- `wlo` out 1: LO write enable; equals `done`.

## Operation
- States:
  - IDLE: `start`&&!`cancel` latches op/opA/opB and goes to CALC.
    - With `MULDIV_FAST_MULT_EN` and a multiply op, it goes to DONE instead.
    - With DIV/DIVU and opB==0, it goes to DONE instead.
  - CALC: 32 iterations counted by a 5-bit counter; goes to DONE after iteration 31.
  - DONE: one cycle; then goes to IDLE.
- Signed ops (MULT, DIV):
  - Operate on absolute values.
  - Negate the product if operand signs differ.
  - Quotient is negative if signs differ; remainder takes the dividend's sign.
- Multiply (iterative): shift-add over a 64-bit accumulator, one multiplier bit per cycle.
- Divide: restoring radix-2. Each iteration shifts the {rem, quot} pair left by one and does a trial subtract of |opB| from rem.
- 0x80000000 / -1 (DIV):
  - lo=0x80000000, hi=0 (two's-complement wrap).
  - No exception.
- Divide by zero:
  - lo=0xFFFFFFFF, hi=opA (unsigned and signed alike).
  - No trap.
- `wHiData`/`wLoData` are registered.
  - They are valid while `done`=1.
  - They hold their last values otherwise.
- `start` while `busy`=1 is ignored. The upstream stage must stall on `busy`.
- `cancel`:
  - In CALC, the unit returns to IDLE on the next edge.
  - In DONE, `done`/`whi`/`wlo` are suppressed combinationally that cycle.
  - In IDLE, it overrides `start`.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `whi`=0, `wlo`=0.
  - `wHiData`=0, `wLoData`=0, counter=0.
- Reset mid-operation aborts with no write on the following cycle.
- Cycle 0 = edge where `start` is accepted. Counting from cycle 0:
  - Iterative ops: CALC cycles 1–32, DONE (write pulse) in cycle 33. 34 cycles `start`-to-IDLE.
  - Fast multiply / divide-by-zero: DONE in cycle 1.
- `busy` rises in cycle 1 and falls once the unit returns to IDLE.
  - A new `start` is accepted in the first IDLE cycle.
  - Back-to-back spacing is 34 cycles (iterative) or 2 cycles (fast).
- HI/LO register update lands on the edge ending the DONE cycle. A dependent MFHI/MFLO reads the new value one cycle after `done`.

## Configuration
- `MULDIV_FAST_MULT_EN`:
  - Defined: MULT/MULTU use a single-cycle 32x32 combinational multiplier with a registered result. DONE in cycle 1; the CALC multiply path is omitted.
  - Undefined: multiply uses the 32-iteration shift-add path.
- Divide is always iterative; results are identical in both builds.

## Structure
- Shared package `muldiv_pkg`: op encodings (OP_MULT..OP_DIVU), state encodings (ST_IDLE/ST_CALC/ST_DONE), iteration count constant 32.
- Reset/valid constants come from the existing shared definitions.
- Sub-module `div_core` contains:
  - the restoring-divide step;
  - the abs/negate sign-fix logic.
- The FSM, counter and multiply path stay in `muldiv_unit`.

## Test plan
- MULT opA=0xFFFFFFFD (−3), opB=7 -> `done` at cycle 33 (cycle 1 with fast EN), hi=0xFFFFFFFF, lo=0xFFFFFFEB, `whi`=`wlo`=1 for one cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002, `done` at cycle 33.
- DIVU 5/0 -> `done` at cycle 1, lo=0xFFFFFFFF, hi=0x00000005. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU started, `cancel` at cycle 10 -> `busy`=0 at cycle 11, no `whi`/`wlo` pulse. `start` re-asserted at cycle 11 accepted.
- `rst` asserted at cycle 20 of a DIV -> all outputs 0 next cycle, no write. `start` during `busy` ignored (result matches the first op only).
